// File: rtl/bus_arbiter4_pkg.sv
// Shared definitions for the 4-requester bus arbiter.
//   NUM_REQ  : number of requesters
//   SEL_W    : width of the encoded requester index
//   CNT_W    : width of the BUSY timeout counter
//   state_e  : arbiter FSM encoding
//   rr_pick  : round-robin winner search starting at a priority pointer
package bus_arbiter4_pkg;

    localparam int NUM_REQ = 4;
    localparam int SEL_W   = 2;
    localparam int CNT_W   = 8;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_e;

    // First set bit of req searching upward from ptr, wrapping mod NUM_REQ.
    // Walk the offsets from highest to lowest so the smallest offset wins last.
    function automatic logic [SEL_W-1:0] rr_pick(input logic [NUM_REQ-1:0] req,
                                                 input logic [SEL_W-1:0]   ptr);
        logic [SEL_W-1:0] idx;
        logic [SEL_W-1:0] win;
        win = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            idx = ptr + SEL_W'(i);
            if (req[idx]) win = idx;
        end
        return win;
    endfunction

endpackage

// File: rtl/bus_arbiter4_mux4.sv
// 4:1 payload / write-flag selector for the shared bus port.
//   sel_i        : encoded requester index
//   d0_i..d3_i   : per-requester payloads (W bits)
//   we_i         : per-requester write flags
//   d_o, we_o    : selected payload and write flag
module mux4
    import bus_arbiter4_pkg::*;
#(
    parameter int W = 32
) (
    input  logic [SEL_W-1:0]   sel_i,
    input  logic [W-1:0]       d0_i,
    input  logic [W-1:0]       d1_i,
    input  logic [W-1:0]       d2_i,
    input  logic [W-1:0]       d3_i,
    input  logic [NUM_REQ-1:0] we_i,
    output logic [W-1:0]       d_o,
    output logic               we_o
);

    always_comb begin
        d_o  = d0_i;
        we_o = we_i[sel_i];
        case (sel_i)
            2'd0:    d_o = d0_i;
            2'd1:    d_o = d1_i;
            2'd2:    d_o = d2_i;
            default: d_o = d3_i;
        endcase
    end

endmodule

// File: rtl/bus_arbiter4.sv
// Round-robin arbiter granting one of four requesters a shared memory port.
//   clk, rst_n        : clock, async active-low reset
//   req_i, we_i       : per-requester request and write flag
//   data0_i..data3_i  : per-requester payloads
//   mem_ready_i       : downstream completes the current transaction
//   mem_req_o, mem_we_o, mem_data_o : shared port
//   sel_o, gnt_o      : encoded / one-hot grant
//   ack_o, err_o      : completion pulse / timeout-abort pulse
module bus_arbiter4
    import bus_arbiter4_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [NUM_REQ-1:0] we_i,
    input  logic [DATA_W-1:0]  data0_i,
    input  logic [DATA_W-1:0]  data1_i,
    input  logic [DATA_W-1:0]  data2_i,
    input  logic [DATA_W-1:0]  data3_i,
    input  logic               mem_ready_i,
    output logic               mem_req_o,
    output logic               mem_we_o,
    output logic [DATA_W-1:0]  mem_data_o,
    output logic [SEL_W-1:0]   sel_o,
    output logic [NUM_REQ-1:0] gnt_o,
    output logic [NUM_REQ-1:0] ack_o,
    output logic               err_o
);

    localparam logic [CNT_W-1:0] TO = CNT_W'(TIMEOUT);

    state_e           state_q, state_d;
    logic [SEL_W-1:0] win_q,   win_d;
    logic [SEL_W-1:0] ptr_q,   ptr_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic [CNT_W-1:0] cnt_inc;

    logic               mux_we;
    logic [NUM_REQ-1:0] gnt, ack;
    logic [SEL_W-1:0]   sel;
    logic               err, mreq;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            win_q   <= '0;
            ptr_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            win_q   <= win_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
        end
    end

    assign cnt_inc = cnt_q + CNT_W'(1);

    always_comb begin
        state_d = state_q;
        win_d   = win_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        gnt     = '0;
        ack     = '0;
        err     = 1'b0;
        mreq    = 1'b0;
        sel     = '0;
        case (state_q)
            IDLE: begin
                if (|req_i) begin
                    win_d   = rr_pick(req_i, ptr_q);
                    cnt_d   = '0;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                mreq = 1'b1;
                gnt  = NUM_REQ'(1) << win_q;
                sel  = win_q;
                // Ready wins over a timeout reached in the same cycle.
                if (mem_ready_i) begin
                    ack     = gnt;
                    state_d = IDLE;
                    ptr_d   = win_q + SEL_W'(1);
                end else begin
                    cnt_d = cnt_inc;
                    if (cnt_inc == TO) begin
                        err     = 1'b1;
                        state_d = IDLE;
                        ptr_d   = win_q + SEL_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // sel is 0 in IDLE, so the mux presents data0_i there.
    mux4 #(.W(DATA_W)) u_mux (
        .sel_i (sel_o),
        .d0_i  (data0_i),
        .d1_i  (data1_i),
        .d2_i  (data2_i),
        .d3_i  (data3_i),
        .we_i  (we_i),
        .d_o   (mem_data_o),
        .we_o  (mux_we)
    );

    assign mem_req_o = mreq;
    assign mem_we_o  = mreq & mux_we;
    assign sel_o     = sel;
    assign gnt_o     = gnt;
    assign ack_o     = ack;
    assign err_o     = err;

endmodule

// File: tb/tb_bus_arbiter4.sv
module tb_bus_arbiter4;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  req_i, we_i, gnt_o, ack_o;
    logic [31:0] data0_i, data1_i, data2_i, data3_i, mem_data_o;
    logic        mem_ready_i, mem_req_o, mem_we_o, err_o;
    logic [1:0]  sel_o;

    bus_arbiter4 #(.DATA_W(32), .TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n), .req_i(req_i), .we_i(we_i),
        .data0_i(data0_i), .data1_i(data1_i), .data2_i(data2_i), .data3_i(data3_i),
        .mem_ready_i(mem_ready_i), .mem_req_o(mem_req_o), .mem_we_o(mem_we_o),
        .mem_data_o(mem_data_o), .sel_o(sel_o), .gnt_o(gnt_o), .ack_o(ack_o), .err_o(err_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] req;
        int         rdy_at;   // BUSY cycle with mem_ready_i=1, 0 = never
        bit         drop;     // drop req_i during BUSY
        logic [3:0] exp_gnt;
        bit         exp_ack;  // 1 = ack expected, 0 = timeout abort
    } vec_t;

    typedef struct {
        logic [3:0]  gnt;
        bit          ack;
        logic [31:0] data;
        logic        we;
    } sb_t;

    sb_t sbq[$];
    int  n_chk = 0;
    int  n_err = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Cycle monitor: protocol invariants plus scoreboard pop at transaction end.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            chk("gnt_onehot0", 64'($onehot0(gnt_o)), 1);
            chk("ack_err_excl", 64'((|ack_o) && err_o), 0);
            if (gnt_o != 4'b0) begin
                if (sbq.size() == 0) begin
                    chk("unexpected_grant", gnt_o, 0);
                end else begin
                    chk("busy_gnt", gnt_o, sbq[0].gnt);
                    chk("busy_mem_req", mem_req_o, 1);
                    chk("busy_data", mem_data_o, sbq[0].data);
                    chk("busy_we", mem_we_o, sbq[0].we);
                    if ((ack_o != 4'b0) || err_o) begin
                        chk("end_ack", ack_o, sbq[0].ack ? sbq[0].gnt : 4'b0);
                        chk("end_err", err_o, !sbq[0].ack);
                        void'(sbq.pop_front());
                    end
                end
            end else begin
                chk("idle_mem_req", mem_req_o, 0);
                chk("idle_ack", ack_o, 0);
                chk("idle_err", err_o, 0);
                chk("idle_we", mem_we_o, 0);
                chk("idle_data", mem_data_o, data0_i);
            end
        end
    end

    // Drive a new request in an IDLE cycle and record what must come out.
    task automatic drive(input logic [3:0] req, input logic [3:0] exp_gnt,
                         input bit exp_ack, input bit fix_d0);
        logic [31:0] d[4];
        logic [3:0]  we;
        int          idx;
        sb_t         e;
        for (int n = 0; n < 4; n++) d[n] = $urandom;
        if (fix_d0) d[0] = 32'hDEAD_BEEF;
        we = 4'($urandom);
        idx = 0;
        for (int n = 0; n < 4; n++) if (exp_gnt[n]) idx = n;
        data0_i = d[0]; data1_i = d[1]; data2_i = d[2]; data3_i = d[3];
        we_i = we; req_i = req; mem_ready_i = 1'b0;
        e.gnt = exp_gnt; e.ack = exp_ack; e.data = d[idx]; e.we = we[idx];
        sbq.push_back(e);
    endtask

    // Called at posedge+1 of an IDLE cycle; returns at posedge+1 of the next IDLE cycle.
    task automatic run_txn(input logic [3:0] req, input int rdy_at, input bit drop,
                           input logic [3:0] exp_gnt, input bit exp_ack, input bit fix_d0);
        drive(req, exp_gnt, exp_ack, fix_d0);
        @(negedge clk);
        chk("pre_grant_idle", gnt_o, 0);
        for (int k = 1; k <= TO; k++) begin
            @(posedge clk); #1;
            mem_ready_i = (k == rdy_at);
            if (drop) req_i = 4'b0;
            @(negedge clk);
            if (k == 1) chk("grant_latency", gnt_o, exp_gnt);
            if (k == rdy_at) chk("ack_cycle", ack_o, exp_gnt);
            if (rdy_at == 0 && k == TO) chk("err_cycle", err_o, 1);
            if (k == rdy_at) break;
        end
        @(posedge clk); #1;
        mem_ready_i = 1'b0;
    endtask

    vec_t tbl[15];

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl = '{
            '{4'b1111, 1, 1'b0, 4'b0001, 1'b1},
            '{4'b1111, 1, 1'b0, 4'b0010, 1'b1},
            '{4'b1111, 1, 1'b0, 4'b0100, 1'b1},
            '{4'b1111, 1, 1'b0, 4'b1000, 1'b1},
            '{4'b1111, 1, 1'b0, 4'b0001, 1'b1},
            '{4'b0010, 1, 1'b0, 4'b0010, 1'b1},
            '{4'b0011, 1, 1'b0, 4'b0001, 1'b1},
            '{4'b0011, 1, 1'b0, 4'b0010, 1'b1},
            '{4'b0100, 0, 1'b0, 4'b0100, 1'b0},
            '{4'b1001, 1, 1'b0, 4'b1000, 1'b1},
            '{4'b0110, 4, 1'b0, 4'b0010, 1'b1},
            '{4'b0100, 3, 1'b1, 4'b0100, 1'b1},
            '{4'b1111, 2, 1'b0, 4'b1000, 1'b1},
            '{4'b0101, 0, 1'b1, 4'b0001, 1'b0},
            '{4'b0101, 1, 1'b0, 4'b0100, 1'b1}
        };

        rst_n = 1'b0; req_i = '0; we_i = '0; mem_ready_i = 1'b0;
        data0_i = '0; data1_i = '0; data2_i = '0; data3_i = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_gnt", gnt_o, 0);
        chk("rst_mem_req", mem_req_o, 0);
        chk("rst_ack", ack_o, 0);
        chk("rst_err", err_o, 0);
        chk("rst_sel", sel_o, 0);
        rst_n = 1'b1;

        // Single requester, ready on the 2nd BUSY cycle.
        run_txn(4'b0001, 2, 1'b0, 4'b0001, 1'b1, 1'b1);

        // Reset mid-BUSY: outputs drop without a clock edge, transaction is lost.
        drive(4'b0100, 4'b0100, 1'b1, 1'b0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("pre_reset_gnt", gnt_o, 4'b0100);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_gnt", gnt_o, 0);
        chk("async_rst_mem_req", mem_req_o, 0);
        chk("async_rst_ack", ack_o, 0);
        chk("async_rst_err", err_o, 0);
        chk("async_rst_sel", sel_o, 0);
        chk("async_rst_we", mem_we_o, 0);
        sbq.delete();
        req_i = 4'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        run_txn(4'b1000, 1, 1'b0, 4'b1000, 1'b1, 1'b0);

        foreach (tbl[i])
            run_txn(tbl[i].req, tbl[i].rdy_at, tbl[i].drop, tbl[i].exp_gnt, tbl[i].exp_ack, 1'b0);

        req_i = 4'b0;
        repeat (3) @(negedge clk);
        chk("scoreboard_empty", sbq.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
